// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-based instruction prefetch queue.
// Issues ibus fetches and hands {pc,inst} pairs to decode in order.
module ifu_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [31:0]       ibus_rdata_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [31:0]       id_inst_o,
  input  logic              id_ready_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     discard_jmp;
  logic [SW-1:0]     credit_used;
  logic [ADDR_W-1:0] jump_pc;
  logic              grant;
  logic              push;
  logic              pop;
  logic              drop;
  logic              rv_old;

  // every slot is reserved at request time, so the FIFO can never overflow
  assign credit_used = SW'(count) + SW'(inflight) + SW'(discard);

  assign ibus_req_o  = !rst && !jump_req_i &&
                       (credit_used < SW'(DEPTH));
  assign ibus_addr_o = fetch_pc;
  assign grant       = ibus_req_o && ibus_gnt_i;

  // stale responses are dropped first; strays with nothing owed are ignored
  assign drop   = ibus_rvalid_i && (discard != '0);
  assign push   = ibus_rvalid_i && (discard == '0) &&
                  (inflight != '0) && !jump_req_i;
  assign pop    = id_valid_o && id_ready_i && !jump_req_i;
  assign rv_old = ibus_rvalid_i &&
                  ((discard != '0) || (inflight != '0));

  assign jump_pc     = jump_pc_i & ~ADDR_W'(3);
  assign discard_jmp = CW'(SW'(discard) + SW'(inflight) +
                       SW'(grant) - SW'(rv_old));

  assign id_valid_o = !rst && (count != '0);
  assign id_pc_o    = pc_q[rd_ptr];
  assign id_inst_o  = inst_q[rd_ptr];

  // control state: reset, then redirect, then normal fetch/response/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_ADDR;
      resp_pc  <= RESET_ADDR;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (jump_req_i) begin
      fetch_pc <= jump_pc;
      resp_pc  <= jump_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= discard_jmp;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        resp_pc <= resp_pc + ADDR_W'(4);
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        discard <= discard - CW'(1);
      end
      inflight <= inflight + CW'(grant) - CW'(push);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, written only on an accepted response
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= resp_pc;
      inst_q[wr_ptr] <= ibus_rdata_i;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: random ibus/decode traffic with an in-order
// memory model and a scoreboard of expected {pc,inst} deliveries.
module tb_ifu_prefetch;

  localparam int ADDR_W = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ibus_req_o;
  logic [ADDR_W-1:0] ibus_addr_o;
  logic              ibus_gnt_i = 1'b0;
  logic              ibus_rvalid_i = 1'b0;
  logic [31:0]       ibus_rdata_i = '0;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [31:0]       id_inst_o;
  logic              id_ready_i = 1'b0;
  logic              jump_req_i = 1'b0;
  logic [ADDR_W-1:0] jump_pc_i = '0;

  ifu_prefetch #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ibus_req_o(ibus_req_o),
    .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i(ibus_rdata_i),
    .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o),
    .id_ready_i(id_ready_i),
    .jump_req_i(jump_req_i),
    .jump_pc_i(jump_pc_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          gnt_pct = 0;
  int          rdy_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rst_cmd = 1'b1;
  bit          jump_now = 1'b0;
  logic [31:0] jump_tgt = '0;
  int          cyc = 0;
  int          last_due = 0;
  int          n_grant = 0;
  logic [31:0] exp_fetch = '0;
  bit          addr_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  mreq_t       mq[$];
  logic [31:0] sb[$];

  bit          mon_hold = 1'b0;
  logic [31:0] mon_pc = '0;
  logic [31:0] mon_inst = '0;
  logic [31:0] mon_exp = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, then observe and update the model
  task automatic cycle();
    int    lat;
    int    due;
    mreq_t m;
    @(negedge clk);
    cyc++;
    rst = rst_cmd;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i = $urandom;
    end
    ibus_gnt_i = ($urandom_range(99) < gnt_pct);
    id_ready_i = ($urandom_range(99) < rdy_pct);
    jump_req_i = jump_now;
    jump_pc_i = jump_tgt;
    jump_now = 1'b0;
    #1;
    if (rst) begin
      mq.delete();
      sb.delete();
      exp_fetch = '0;
      last_due = 0;
      addr_hold = 1'b0;
      return;
    end
    if (addr_hold && !jump_req_i) begin
      chk("req_hold", ibus_req_o, 1);
      chk("addr_hold", ibus_addr_o, prev_addr);
    end
    addr_hold = ibus_req_o && !ibus_gnt_i;
    prev_addr = ibus_addr_o;
    if (jump_req_i) begin
      chk("req_on_jump", ibus_req_o, 0);
      sb.delete();
      exp_fetch = jump_pc_i & ~32'h3;
    end else if (ibus_req_o && ibus_gnt_i) begin
      chk("fetch_addr", ibus_addr_o, exp_fetch);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = ibus_addr_o;
      m.due = due;
      mq.push_back(m);
      sb.push_back(ibus_addr_o);
      exp_fetch += 32'd4;
      n_grant++;
      chk("credit", sb.size() <= DEPTH, 1);
    end
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    cycle();
    cycle();
    rst_cmd = 1'b0;
    n_grant = 0;
  endtask

  task automatic wait_valid(input string name, input int bound,
                            input logic [31:0] exp_pc);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (id_valid_o) break;
    end
    chk({name, "_valid"}, id_valid_o, 1);
    chk({name, "_pc"}, id_pc_o, exp_pc);
  endtask

  // monitor: compare every instruction decode consumes
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        mon_hold = 1'b0;
        continue;
      end
      if (mon_hold) begin
        chk("id_hold_valid", id_valid_o, 1);
        chk("id_hold_pc", id_pc_o, mon_pc);
        chk("id_hold_inst", id_inst_o, mon_inst);
      end
      mon_hold = id_valid_o && !id_ready_i && !jump_req_i;
      mon_pc = id_pc_o;
      mon_inst = id_inst_o;
      if (id_valid_o && id_ready_i && !jump_req_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL id_unexpected: got pc %0h want none", id_pc_o);
        end else begin
          mon_exp = sb.pop_front();
          chk("id_pc", id_pc_o, mon_exp);
          chk("id_inst", id_inst_o, mem_word(mon_exp));
        end
      end
    end
  end

  initial begin
    int first;

    // reset outputs, then grant held off for five cycles
    rst_cmd = 1'b1;
    cycle();
    cycle();
    chk("rst_req", ibus_req_o, 0);
    chk("rst_valid", id_valid_o, 0);
    rst_cmd = 1'b0;
    gnt_pct = 0;
    rdy_pct = 100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_addr", ibus_addr_o, 0);
      chk("stall_req", ibus_req_o, 1);
    end
    gnt_pct = 100;
    cycle();
    gnt_pct = 0;
    cycle();
    chk("after_stall_addr", ibus_addr_o, 32'h4);

    // streaming: one instruction per cycle after two cycles
    do_reset();
    gnt_pct = 100;
    rdy_pct = 100;
    lat_min = 1;
    lat_max = 1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (id_valid_o && first < 0) first = k;
      if (k >= 2) begin
        chk("stream_valid", id_valid_o, 1);
        chk("stream_pc", id_pc_o, 32'((k - 2) * 4));
      end
    end
    chk("first_latency", first, 2);

    // decode stalled: credits stop fetch after DEPTH grants
    do_reset();
    gnt_pct = 100;
    rdy_pct = 0;
    for (int k = 0; k < 10; k++) cycle();
    chk("stall_grants", n_grant, DEPTH);
    chk("stall_req_low", ibus_req_o, 0);
    chk("stall_id_valid", id_valid_o, 1);
    chk("stall_id_pc", id_pc_o, 0);
    rdy_pct = 100;
    for (int k = 0; k < 8; k++) cycle();

    // reset with queued and in-flight fetches
    do_reset();
    gnt_pct = 100;
    rdy_pct = 0;
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 5; k++) cycle();
    rst_cmd = 1'b1;
    cycle();
    chk("midrst_req", ibus_req_o, 0);
    chk("midrst_valid", id_valid_o, 0);
    rst_cmd = 1'b0;
    cycle();
    chk("postrst_addr", ibus_addr_o, 0);
    chk("postrst_valid", id_valid_o, 0);
    rdy_pct = 100;
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 10; k++) cycle();

    // jump with two fetches outstanding
    do_reset();
    gnt_pct = 100;
    rdy_pct = 100;
    lat_min = 3;
    lat_max = 3;
    cycle();
    cycle();
    jump_tgt = 32'h103;
    jump_now = 1'b1;
    cycle();
    cycle();
    chk("jump_addr", ibus_addr_o, 32'h100);
    wait_valid("jump35", 20, 32'h100);

    // jump while a grant is offered and a response lands
    do_reset();
    gnt_pct = 100;
    rdy_pct = 100;
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 4; k++) cycle();
    jump_tgt = 32'h200;
    jump_now = 1'b1;
    cycle();
    wait_valid("jump36", 20, 32'h200);

    // randomized traffic with jumps and occasional resets
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        rdy_pct = $urandom_range(100, 20);
      end
      if ($urandom_range(999) < 3) begin
        rst_cmd = 1'b1;
        cycle();
        rst_cmd = 1'b0;
        continue;
      end
      if ($urandom_range(99) < 4) begin
        jump_now = 1'b1;
        jump_tgt = $urandom;
      end
      cycle();
    end

    // drain: all granted work must reach decode
    gnt_pct = 0;
    rdy_pct = 100;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (sb.size() == 0 && mq.size() == 0) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_valid", id_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
